// File: rtl/pong_pkg.sv
// Shared encodings for the pong controller and the game state machine it drives.
package pong_pkg;

    localparam logic [4:0] ST_IDLE   = 5'b00001;
    localparam logic [4:0] ST_SERVE  = 5'b00010;
    localparam logic [4:0] ST_PLAY   = 5'b00100;
    localparam logic [4:0] ST_SCORED = 5'b01000;
    localparam logic [4:0] ST_OVER   = 5'b10000;

    typedef enum logic [1:0] {
        GS_INIT    = 2'd0,
        GS_READ    = 2'd1,
        GS_UPDATE  = 2'd2,
        GS_COLLIDE = 2'd3
    } game_state_e;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

endpackage

// File: rtl/pong_tick_gen.sv
// Frame divider: one-cycle tick every TICK_DIV enabled, unheld cycles.
module pong_tick_gen #(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic hold,
    output logic tick
);

    localparam int unsigned W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    // hold freezes the count in place so a paused frame resumes where it stopped
    assign tick = en && !hold && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Round/match sequencer: serves, paces play, scores points and ends the match.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 1000000,
    parameter int unsigned SERVE_CYCLES  = 50000000,
    parameter int unsigned SCORED_CYCLES = 16,
    parameter int unsigned WIN_SCORE     = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_req,
    input  logic       pause,
    input  logic       point_1,
    input  logic       point_2,
    output logic       start,
    output logic       gameover,
    output logic       sm_rst,
    output logic       frame_tick,
    output logic       serve_dir,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner,
    output logic [4:0] ctrl_state
);

    localparam int unsigned SV_W = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
    localparam int unsigned SC_W = $clog2(SCORED_CYCLES);
    localparam logic [SV_W-1:0] SERVE_LAST  = SV_W'(SERVE_CYCLES - 1);
    localparam logic [SC_W-1:0] SCORED_LAST = SC_W'(SCORED_CYCLES - 1);
    localparam logic [3:0]      WIN4        = 4'(WIN_SCORE);

    logic [4:0]      state;
    logic [SV_W-1:0] serve_cnt;
    logic [SC_W-1:0] scored_cnt;
    logic            p1_q, p2_q, rst_q;
    logic            serve_last, scored_last;
    logic            p1_edge, p2_edge, win_reached;

    assign serve_last  = (state == ST_SERVE)  && (serve_cnt == SERVE_LAST);
    assign scored_last = (state == ST_SCORED) && (scored_cnt == SCORED_LAST);
    assign p1_edge     = point_1 && !p1_q;
    assign p2_edge     = point_2 && !p2_q;
    assign win_reached = (score1 == WIN4) || (score2 == WIN4);

    assign start      = serve_last;
    assign gameover   = (state == ST_SCORED) || (state == ST_OVER);
    assign sm_rst     = rst_q || scored_last;
    assign ctrl_state = state;

    pong_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_PLAY),
        .hold (pause),
        .tick (frame_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            score1     <= '0;
            score2     <= '0;
            winner     <= WINNER_NONE;
            serve_dir  <= 1'b1;
            serve_cnt  <= '0;
            scored_cnt <= '0;
            p1_q       <= 1'b0;
            p2_q       <= 1'b0;
            rst_q      <= 1'b1;
        end else begin
            rst_q      <= 1'b0;
            // clearing with sm_rst lets a flag that is still high be seen afresh, but only PLAY counts it
            p1_q       <= sm_rst ? 1'b0 : point_1;
            p2_q       <= sm_rst ? 1'b0 : point_2;
            serve_cnt  <= (state == ST_SERVE && !serve_last) ? serve_cnt + 1'b1 : '0;
            scored_cnt <= (state == ST_SCORED && !scored_last) ? scored_cnt + 1'b1 : '0;

            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start_req) begin
                        state     <= ST_SERVE;
                        score1    <= '0;
                        score2    <= '0;
                        winner    <= WINNER_NONE;
                        serve_dir <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (serve_last) state <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (p1_edge || p2_edge) begin
                        state <= ST_SCORED;
                        if (p1_edge && !p2_edge) begin
                            score1    <= score1 + 4'd1;
                            serve_dir <= 1'b1;
                        end else if (p2_edge && !p1_edge) begin
                            score2    <= score2 + 4'd1;
                            serve_dir <= 1'b0;
                        end
                    end
                end
                ST_SCORED: begin
                    if (scored_last) begin
                        if (win_reached) begin
                            state  <= ST_OVER;
                            winner <= (score1 == WIN4) ? WINNER_P1 : WINNER_P2;
                        end else begin
                            state <= ST_SERVE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
